// File: rtl/kb_rx_ctrl.sv
// -----------------------------------------------------------------------------
// kb_rx_ctrl
//
// Synchronous receive sequencer for the PS/2 keyboard port. The raw keyboard
// clock and data pins are synchronized into the clk domain. Falling edges of
// the synchronized keyboard clock step an 11-bit frame state machine:
// start, 8 data bits LSB first, odd parity, stop. A watchdog aborts stalled
// frames. Each accepted byte is held for a valid/ready consumer.
//
// Optional feature macro: KB_RX_PARITY_CHK_EN
//   defined   : parity is checked; failing frames are dropped and pulse
//               err_parity.
//   undefined : the parity bit is sampled and ignored; err_parity is tied 0.
//
// Parameters
//   SYNC_STAGES  synchronizer depth on ps2_clk / ps2_data (values below 2
//                are raised to 2)
//   TIMEOUT_CYC  clk cycles without a keyboard-clock fall before an
//                in-progress frame is aborted
//   ERR_CNT_W    width of the saturating error counter
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   ps2_clk      raw keyboard clock (asynchronous)
//   ps2_data     raw keyboard data (asynchronous)
//   rx_data      held scan code
//   rx_valid     rx_data valid, held until accepted
//   rx_ready     consumer accepts when rx_valid && rx_ready
//   busy         a frame is in progress
//   err_frame    one-cycle pulse: bad start, bad stop or watchdog timeout
//   err_parity   one-cycle pulse: parity failure
//   err_overrun  one-cycle pulse: completed byte dropped, holding reg full
//   err_count    saturating count of cycles with any error pulse
//
// State table
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for a start bit
//   ST_DATA   | shifting in data bits 0..7 (bit_cnt selects the slot)
//   ST_PARITY | waiting for the parity bit
//   ST_STOP   | waiting for the stop bit
//   ST_DONE   | one cycle: parity decision and holding-register load
// -----------------------------------------------------------------------------
module kb_rx_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 5000,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 err_frame,
    output logic                 err_parity,
    output logic                 err_overrun,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int WD_W   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
    localparam logic [2:0] ST_PARITY = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // ------------------------------------------------------------------
    // Input synchronizers. Reset to 1 so a reset on an idle bus does not
    // manufacture a falling edge.
    // ------------------------------------------------------------------
    logic [SYNC_N-1:0] clk_sync_q;
    logic [SYNC_N-1:0] data_sync_q;
    logic              clk_prev_q;
    logic              fall_q;
    logic              clk_s;
    logic              data_s;

    assign clk_s  = clk_sync_q[SYNC_N-1];
    assign data_s = data_sync_q[SYNC_N-1];

    // fall_q is registered, which places the pulse SYNC_STAGES+1 cycles
    // after the pin edge; data_s is then long settled for sampling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_N-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_N-2:0], ps2_data};
            clk_prev_q  <= clk_s;
            fall_q      <= clk_prev_q & ~clk_s;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM, watchdog and holding register
    // ------------------------------------------------------------------
    logic [2:0]           state_q,       state_d;
    logic [2:0]           bit_cnt_q,     bit_cnt_d;
    logic [7:0]           shift_q,       shift_d;
    logic [WD_W-1:0]      wd_q,          wd_d;
    logic [7:0]           rx_data_q,     rx_data_d;
    logic                 rx_valid_q,    rx_valid_d;
    logic                 err_frame_q,   err_frame_d;
    logic                 err_overrun_q, err_overrun_d;
    logic [ERR_CNT_W-1:0] err_count_q,   err_count_d;
    logic                 in_frame;
    logic                 timeout;
    logic                 par_ok;
    logic                 load;
    logic                 any_err;
`ifdef KB_RX_PARITY_CHK_EN
    logic                 par_q,         par_d;
    logic                 err_parity_q,  err_parity_d;
`endif

    assign in_frame = (state_q == ST_DATA) || (state_q == ST_PARITY) ||
                      (state_q == ST_STOP);

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        err_frame_d   = 1'b0;
        err_overrun_d = 1'b0;
        load          = 1'b0;
        par_ok        = 1'b1;
`ifdef KB_RX_PARITY_CHK_EN
        par_d         = par_q;
        err_parity_d  = 1'b0;
`endif

        if (fall_q || (state_q == ST_IDLE)) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + WD_W'(1);
        end

        // A fall in the same cycle restarts the watchdog, so it never
        // competes with a real bit.
        timeout = in_frame && !fall_q && (wd_d == WD_W'(TIMEOUT_CYC - 1));

        if (timeout) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = 3'd0;
            err_frame_d = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    bit_cnt_d = 3'd0;
                    if (fall_q) begin
                        if (!data_s) begin
                            state_d = ST_DATA;
                        end else begin
                            err_frame_d = 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (fall_q) begin
                        shift_d[bit_cnt_q] = data_s;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_PARITY;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (fall_q) begin
`ifdef KB_RX_PARITY_CHK_EN
                        par_d = data_s;
`endif
                        state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (fall_q) begin
                        if (!data_s) begin
                            err_frame_d = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
`ifdef KB_RX_PARITY_CHK_EN
                    par_ok = ^{shift_q, par_q};
`endif
                    if (!par_ok) begin
`ifdef KB_RX_PARITY_CHK_EN
                        err_parity_d = 1'b1;
`endif
                    end else if (!rx_valid_q || rx_ready) begin
                        load = 1'b1;
                    end else begin
                        err_overrun_d = 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                end
            endcase
        end

        // A load in the accepting cycle keeps rx_valid high with new data.
        if (load) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

`ifdef KB_RX_PARITY_CHK_EN
        any_err = err_frame_d | err_overrun_d | err_parity_d;
`else
        any_err = err_frame_d | err_overrun_d;
`endif

        // Counted from the next-state pulses so the count moves together
        // with the visible pulse.
        err_count_d = err_count_q;
        if (any_err && (err_count_q != {ERR_CNT_W{1'b1}})) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            wd_q          <= '0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            err_frame_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            wd_q          <= wd_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            err_frame_q   <= err_frame_d;
            err_overrun_q <= err_overrun_d;
            err_count_q   <= err_count_d;
        end
    end

`ifdef KB_RX_PARITY_CHK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_q        <= 1'b0;
            err_parity_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            err_parity_q <= err_parity_d;
        end
    end

    assign err_parity = err_parity_q;
`else
    assign err_parity = 1'b0;
`endif

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign busy        = (state_q != ST_IDLE);
    assign err_frame   = err_frame_q;
    assign err_overrun = err_overrun_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_kb_rx_ctrl.sv
module tb_kb_rx_ctrl;

    localparam int S = 2;    // synchronizer depth
    localparam int T = 60;   // watchdog timeout in clk cycles
    localparam int H = 6;    // keyboard clock half period in clk cycles

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       err_frame;
    logic       err_parity;
    logic       err_overrun;
    logic [7:0] err_count;

    kb_rx_ctrl #(
        .SYNC_STAGES(S),
        .TIMEOUT_CYC(T),
        .ERR_CNT_W  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .busy       (busy),
        .err_frame  (err_frame),
        .err_parity (err_parity),
        .err_overrun(err_overrun),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_shown = 0;
    int cyc = 0;
    int last_drive = 0;

    // Keyboard falls as seen by the receiver: the clk index at which each
    // driven fall is acted on, and the data bit it carries.
    int   fq[$];
    logic fd[$];

    // Behavioural model: a frame is a start bit followed by a list of 10
    // collected bits (8 data, parity, stop).
    logic [7:0] m_data   = 8'h00;
    logic       m_valid  = 1'b0;
    logic       m_in_frame = 1'b0;
    logic       m_done   = 1'b0;
    logic       m_bits[$];
    int         m_last_fall = 0;
    logic       m_ef = 1'b0;
    logic       m_ep = 1'b0;
    logic       m_eo = 1'b0;
    int         m_cnt = 0;

    // Monitors for the directed checks
    int valid_hi = 0;
    int ef_cnt = 0;
    int ep_cnt = 0;
    int eo_cnt = 0;
    int ef_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_shown < 40) begin
                n_shown++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
            end
        end
    endtask

    task automatic model_clear();
        m_data     = 8'h00;
        m_valid    = 1'b0;
        m_in_frame = 1'b0;
        m_done     = 1'b0;
        m_bits.delete();
        m_ef = 1'b0;
        m_ep = 1'b0;
        m_eo = 1'b0;
        m_cnt = 0;
        fq.delete();
        fd.delete();
    endtask

    task automatic model_step();
        logic       fall;
        logic       d;
        logic       ok;
        logic       load;
        logic [7:0] b;
        fall = 1'b0;
        d    = 1'b0;
        load = 1'b0;
        b    = 8'h00;
        if (fq.size() > 0 && fq[0] == cyc) begin
            fall = 1'b1;
            d    = fd[0];
            void'(fq.pop_front());
            void'(fd.pop_front());
        end
        m_ef = 1'b0;
        m_ep = 1'b0;
        m_eo = 1'b0;
        if (m_done) begin
            m_done = 1'b0;
            for (int i = 0; i < 8; i++) b[i] = m_bits[i];
`ifdef KB_RX_PARITY_CHK_EN
            ok = (($countones({b, m_bits[8]}) % 2) == 1);
`else
            ok = 1'b1;
`endif
            if (!ok) m_ep = 1'b1;
            else if (!m_valid || rx_ready) begin
                load   = 1'b1;
                m_data = b;
            end else m_eo = 1'b1;
        end else if (fall) begin
            m_last_fall = cyc;
            if (!m_in_frame) begin
                if (d == 1'b0) begin
                    m_in_frame = 1'b1;
                    m_bits.delete();
                end else m_ef = 1'b1;
            end else begin
                m_bits.push_back(d);
                if (m_bits.size() == 10) begin
                    m_in_frame = 1'b0;
                    if (d) m_done = 1'b1;
                    else   m_ef = 1'b1;
                end
            end
        end else if (m_in_frame && (cyc - m_last_fall == T - 1)) begin
            m_ef = 1'b1;
            m_in_frame = 1'b0;
        end
        if (load) m_valid = 1'b1;
        else if (m_valid && rx_ready) m_valid = 1'b0;
        if ((m_ef || m_ep || m_eo) && m_cnt < 255) m_cnt++;
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) model_step();
    end

    always @(negedge reset) model_clear();

    // Per-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        chk("rx_data",     32'(rx_data),     32'(m_data));
        chk("rx_valid",    32'(rx_valid),    32'(m_valid));
        chk("busy",        32'(busy),        32'(m_in_frame | m_done));
        chk("err_frame",   32'(err_frame),   32'(m_ef));
        chk("err_parity",  32'(err_parity),  32'(m_ep));
        chk("err_overrun", 32'(err_overrun), 32'(m_eo));
        chk("err_count",   32'(err_count),   32'(m_cnt));
        if (rx_valid)    valid_hi++;
        if (err_parity)  ep_cnt++;
        if (err_overrun) eo_cnt++;
        if (err_frame) begin
            ef_cnt++;
            ef_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        valid_hi = 0;
        ef_cnt = 0;
        ep_cnt = 0;
        eo_cnt = 0;
    endtask

    task automatic drive_bit(input logic d);
        ps2_data = d;
        tick(H);
        ps2_clk = 1'b0;
        last_drive = cyc;
        fq.push_back(cyc + S + 2);
        fd.push_back(d);
        tick(H);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_good, input logic stop);
        logic p;
        p = par_good ? ~^b : ^b;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(p);
        drive_bit(stop);
        tick(8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        tick(3);
        chk("rst_rx_data",   32'(rx_data),   32'h00);
        chk("rst_rx_valid",  32'(rx_valid),  32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_err_frame", 32'(err_frame), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        reset = 1'b1;
        tick(3);

        // Good frame, consumer ready
        rx_ready = 1'b1;
        clr_mon();
        send_frame(8'h1C, 1'b1, 1'b1);
        chk("f1C_data",      32'(rx_data),   32'h1C);
        chk("f1C_valid_cyc", 32'(valid_hi),  32'd1);
        chk("f1C_err_count", 32'(err_count), 32'd0);

        // Wrong parity
        clr_mon();
        send_frame(8'h1C, 1'b0, 1'b1);
`ifdef KB_RX_PARITY_CHK_EN
        chk("par_pulse",     32'(ep_cnt),    32'd1);
        chk("par_valid_cyc", 32'(valid_hi),  32'd0);
        chk("par_err_count", 32'(err_count), 32'd1);
`else
        chk("par_data",      32'(rx_data),   32'h1C);
        chk("par_valid_cyc", 32'(valid_hi),  32'd1);
        chk("par_pulse",     32'(ep_cnt),    32'd0);
`endif

        // Overrun: consumer stalled across two frames
        rx_ready = 1'b0;
        clr_mon();
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        chk("ovr_data",  32'(rx_data),  32'hF0);
        chk("ovr_pulse", 32'(eo_cnt),   32'd1);
        chk("ovr_valid", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        tick(1);
        chk("ovr_accept_valid", 32'(rx_valid), 32'd0);

        // Watchdog: start + 3 data bits, then the keyboard clock stalls
        clr_mon();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        for (int i = 0; i < T + 40 && ef_cnt == 0; i++) tick(1);
        chk("wd_pulse",   32'(ef_cnt), 32'd1);
        chk("wd_latency", 32'(ef_cyc - last_drive), 32'(S + 1 + T));
        chk("wd_busy",    32'(busy),   32'd0);
        clr_mon();
        send_frame(8'h5A, 1'b1, 1'b1);
        chk("f5A_data",      32'(rx_data),  32'h5A);
        chk("f5A_valid_cyc", 32'(valid_hi), 32'd1);

        // Bad stop bit
        clr_mon();
        send_frame(8'h1C, 1'b1, 1'b0);
        chk("stop_pulse",     32'(ef_cnt),   32'd1);
        chk("stop_valid_cyc", 32'(valid_hi), 32'd0);

        // Error counter saturation via repeated bad start bits
        repeat (260) drive_bit(1'b1);
        tick(8);
        chk("sat_count", 32'(err_count), 32'd255);
        clr_mon();
        drive_bit(1'b1);
        tick(8);
        chk("sat_pulse", 32'(ef_cnt),    32'd1);
        chk("sat_hold",  32'(err_count), 32'd255);

        // Reset after the 4th data bit of 0x1C
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        tick(2);
        reset = 1'b0;
        #1;
        chk("mid_rst_rx_data",   32'(rx_data),   32'h00);
        chk("mid_rst_rx_valid",  32'(rx_valid),  32'h0);
        chk("mid_rst_busy",      32'(busy),      32'h0);
        chk("mid_rst_err_count", 32'(err_count), 32'h0);
        tick(3);
        reset = 1'b1;
        tick(2);
        // Leftover bits of the interrupted frame: 1,0,0,0, parity 0, stop 1
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        tick(T + 20);
        chk("rec_busy", 32'(busy), 32'd0);
        clr_mon();
        send_frame(8'h32, 1'b1, 1'b1);
        chk("f32_data",      32'(rx_data),  32'h32);
        chk("f32_valid_cyc", 32'(valid_hi), 32'd1);

        tick(4);
        if (n_fail == 0) begin
            $display("PASS: %0d/%0d checks passed", n_pass, n_chk);
        end else begin
            $display("FAIL: %0d/%0d checks failed", n_fail, n_chk);
        end
        $finish;
    end

endmodule
